// File: rtl/uart_pkg.sv
// Shared constants and helpers for the UART baud generator.
package uart_pkg;

  // Default parameter values.
  localparam int CNTR_W_DEF = 13;
  localparam int OVS_DEF    = 16;
  localparam int FRAC_W_DEF = 3;

  // Legal parameter ranges.
  localparam int CNTR_W_MIN = 8;
  localparam int CNTR_W_MAX = 16;
  localparam int FRAC_W_MIN = 1;
  localparam int FRAC_W_MAX = 8;
  localparam int OVS_LEGAL_0 = 4;
  localparam int OVS_LEGAL_1 = 8;
  localparam int OVS_LEGAL_2 = 16;

  // Per-cycle action of the divisor counter, decoded once and shared by all
  // the state registers so they cannot disagree about what happened.
  typedef enum logic [2:0] {
    ACT_HOLD    = 3'd0,  // enable low: freeze everything
    ACT_CLR     = 3'd1,  // sync_clr: restart phase
    ACT_TICK    = 3'd2,  // cntr hit zero, no stretch owed: emit tick, reload
    ACT_STRETCH = 3'd3,  // cntr at zero but a carry is owed: burn one cycle
    ACT_COUNT   = 3'd4   // cntr non-zero: count down
  } baud_act_e;

  // Ceiling log2, used for the oversample phase width.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res++;
      v = v >> 1;
    end
    return res;
  endfunction

  function automatic bit ovs_legal(input int ovs);
    return (ovs == OVS_LEGAL_0) || (ovs == OVS_LEGAL_1) || (ovs == OVS_LEGAL_2);
  endfunction

endpackage

// File: rtl/uart_baud_frac_acc.sv
// Fractional accumulator: adds the fraction on each tick and owes one
// stretched cycle whenever the accumulator carries out.
module uart_baud_frac_acc
  import uart_pkg::*;
#(
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              adv,
  input  logic              consume,
  input  logic [FRAC_W-1:0] frac,
  output logic              stretch_pend
);

  logic [FRAC_W-1:0] acc;
  logic [FRAC_W:0]   sum;

  // Sum with carry out; the carry becomes the stretch request.
  always_comb begin
    sum = {1'b0, acc} + {1'b0, frac};
  end

  // Accumulator and pending-stretch flag; clr wins over everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc          <= '0;
      stretch_pend <= 1'b0;
    end else if (clr) begin
      acc          <= '0;
      stretch_pend <= 1'b0;
    end else if (adv) begin
      acc          <= sum[FRAC_W-1:0];
      stretch_pend <= sum[FRAC_W];
    end else if (consume) begin
      stretch_pend <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_baud_gen.sv
// UART baud rate generator: fractional divisor producing an oversample tick,
// a once-per-bit transmit pulse and a mid-bit receive sample pulse.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CNTR_W  = CNTR_W_DEF,
  parameter int OVS     = OVS_DEF,
  parameter int FRAC_W  = FRAC_W_DEF,
  parameter int FRAC_EN = 1,
  localparam int PH_W   = clog2(OVS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [CNTR_W-1:0] baud_val,
  input  logic [FRAC_W-1:0] baud_frac,
  input  logic              baud_load,
  input  logic              sync_clr,
  output logic              baud_tick,
  output logic              xmit_pulse,
  output logic              rx_sample,
  output logic [PH_W-1:0]   ovs_phase
);

  // Elaboration-time parameter legality.
  if (CNTR_W < CNTR_W_MIN || CNTR_W > CNTR_W_MAX) begin : g_bad_cntr_w
    $fatal(1, "uart_baud_gen: CNTR_W must be within 8..16");
  end
  if (!ovs_legal(OVS)) begin : g_bad_ovs
    $fatal(1, "uart_baud_gen: OVS must be 4, 8 or 16");
  end
  if (FRAC_W < FRAC_W_MIN || FRAC_W > FRAC_W_MAX) begin : g_bad_frac_w
    $fatal(1, "uart_baud_gen: FRAC_W must be within 1..8");
  end
  if (FRAC_EN != 0 && FRAC_EN != 1) begin : g_bad_frac_en
    $fatal(1, "uart_baud_gen: FRAC_EN must be 0 or 1");
  end

  localparam logic [PH_W-1:0] PH_XMIT = PH_W'(OVS - 1);
  localparam logic [PH_W-1:0] PH_RX   = PH_W'(OVS / 2 - 1);

  logic [CNTR_W-1:0] val_shadow;
  logic [FRAC_W-1:0] frac_shadow;
  logic [CNTR_W-1:0] cntr;
  logic              stretch_pend;
  baud_act_e         act;

  // Integer divisor shadow; only consulted at reload, so a load mid-period
  // never disturbs the period in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      val_shadow <= '0;
    end else if (baud_load) begin
      val_shadow <= baud_val;
    end
  end

  if (FRAC_EN != 0) begin : g_frac
    // Fractional divisor shadow, same load semantics as the integer part.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        frac_shadow <= '0;
      end else if (baud_load) begin
        frac_shadow <= baud_frac;
      end
    end
  end else begin : g_no_frac
    logic unused_frac;
    assign unused_frac = ^baud_frac;
    assign frac_shadow = '0;
  end

  // Decode the cycle's action; sync_clr beats enable and the tick condition.
  always_comb begin
    act = ACT_HOLD;
    if (sync_clr) begin
      act = ACT_CLR;
    end else if (enable) begin
      if (cntr == '0) begin
        act = stretch_pend ? ACT_STRETCH : ACT_TICK;
      end else begin
        act = ACT_COUNT;
      end
    end
  end

  // Divisor down-counter; terminal count is zero, reload from the shadow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cntr <= '0;
    end else begin
      case (act)
        ACT_CLR:   cntr <= '0;
        ACT_TICK:  cntr <= val_shadow;
        ACT_COUNT: cntr <= cntr - CNTR_W'(1);
        default:   cntr <= cntr;
      endcase
    end
  end

  uart_baud_frac_acc #(
    .FRAC_W (FRAC_W)
  ) u_frac_acc (
    .clk          (clk),
    .reset_n      (reset_n),
    .clr          (act == ACT_CLR),
    .adv          (act == ACT_TICK),
    .consume      (act == ACT_STRETCH),
    .frac         (frac_shadow),
    .stretch_pend (stretch_pend)
  );

  // Oversample phase; wraps naturally because OVS is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovs_phase <= '0;
    end else if (act == ACT_CLR) begin
      ovs_phase <= '0;
    end else if (act == ACT_TICK) begin
      ovs_phase <= ovs_phase + PH_W'(1);
    end
  end

  // Registered pulses, decoded from the phase before it increments.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      baud_tick  <= 1'b0;
      xmit_pulse <= 1'b0;
      rx_sample  <= 1'b0;
    end else begin
      baud_tick  <= (act == ACT_TICK);
      xmit_pulse <= (act == ACT_TICK) && (ovs_phase == PH_XMIT);
      rx_sample  <= (act == ACT_TICK) && (ovs_phase == PH_RX);
    end
  end

endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed bench for uart_baud_gen at default parameters
// (CNTR_W=13, OVS=16, FRAC_W=3, FRAC_EN=1).
module tb_uart_baud_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [12:0] baud_val;
  logic [2:0]  baud_frac;
  logic        baud_load;
  logic        sync_clr;
  logic        baud_tick;
  logic        xmit_pulse;
  logic        rx_sample;
  logic [3:0]  ovs_phase;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_baud_gen dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .baud_val   (baud_val),
    .baud_frac  (baud_frac),
    .baud_load  (baud_load),
    .sync_clr   (sync_clr),
    .baud_tick  (baud_tick),
    .xmit_pulse (xmit_pulse),
    .rx_sample  (rx_sample),
    .ovs_phase  (ovs_phase)
  );

  // Load divisor and restart phase while stopped, then enable.
  // Called and returns at 1 time unit after a rising edge.
  task automatic setup(input logic [12:0] v, input logic [2:0] f);
    enable    = 1'b0;
    baud_val  = v;
    baud_frac = f;
    baud_load = 1'b1;
    sync_clr  = 1'b1;
    @(posedge clk); #1;
    baud_load = 1'b0;
    sync_clr  = 1'b0;
    enable    = 1'b1;
  endtask

  // Count edges until baud_tick is seen; optionally pulse baud_load once
  // after edge number load_at. n = -1 on timeout.
  task automatic wait_tick(input int load_at, input logic [12:0] lval,
                           input logic [2:0] lfrac, output int n);
    bit done;
    done = 1'b0;
    n = 0;
    while (!done && n < 300) begin
      @(posedge clk); #1;
      n++;
      baud_load = 1'b0;
      if (baud_tick) begin
        done = 1'b1;
      end else if (n == load_at) begin
        baud_load = 1'b1;
        baud_val  = lval;
        baud_frac = lfrac;
      end
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_tick timeout: no baud_tick within %0d clk", n);
      n = -1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; baud_load = 1'b0; sync_clr = 1'b0;
    baud_val = '0; baud_frac = '0;
    repeat (2) @(posedge clk); #1;
    n_cmp++;
    if ({baud_tick, xmit_pulse, rx_sample, ovs_phase} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_state: got %b want 0000000",
               {baud_tick, xmit_pulse, rx_sample, ovs_phase});
    end
    // Shadow is zero after reset: tick every cycle from the first edge.
    reset_n = 1'b1; enable = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({baud_tick, rx_sample, xmit_pulse, ovs_phase} !==
          {1'b1, i == 8, i == 16, 4'(i)}) begin
        n_bad++;
        $display("FAIL reset_release_div0 edge %0d: got %b want %b", i,
                 {baud_tick, rx_sample, xmit_pulse, ovs_phase},
                 {1'b1, i == 8, i == 16, 4'(i)});
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_basic();
    int n;
    setup(13'd3, 3'd0);
    for (int i = 1; i <= 16; i++) begin
      wait_tick(0, '0, '0, n);
      n_cmp++;
      if (n !== ((i == 1) ? 1 : 4) || {rx_sample, xmit_pulse} !== {i == 8, i == 16}) begin
        n_bad++;
        $display("FAIL basic tick %0d: period %0d rx/xmit %b want period %0d rx/xmit %b",
                 i, n, {rx_sample, xmit_pulse}, (i == 1) ? 1 : 4, {i == 8, i == 16});
      end
    end
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!xmit_pulse && n < 200);
    n_cmp++;
    if (n !== 64) begin
      n_bad++;
      $display("FAIL basic xmit_spacing: got %0d clk want 64", n);
    end
  endtask

  task automatic test_frac_half();
    int n, sum;
    setup(13'd3, 3'd4);
    wait_tick(0, '0, '0, n);
    sum = 0;
    for (int i = 0; i < 8; i++) begin
      wait_tick(0, '0, '0, n);
      sum += n;
      n_cmp++;
      if (n !== ((i % 2 == 0) ? 4 : 5)) begin
        n_bad++;
        $display("FAIL frac4 period %0d: got %0d want %0d", i, n, (i % 2 == 0) ? 4 : 5);
      end
    end
    n_cmp++;
    if (sum !== 36) begin
      n_bad++;
      $display("FAIL frac4 span: got %0d want 36", sum);
    end
  endtask

  task automatic test_frac_max();
    int n, sum, str;
    setup(13'd3, 3'd7);
    wait_tick(0, '0, '0, n);
    sum = 0; str = 0;
    for (int i = 0; i < 8; i++) begin
      wait_tick(0, '0, '0, n);
      sum += n;
      if (n == 5) str++;
    end
    n_cmp++;
    if (sum !== 39 || str !== 7) begin
      n_bad++;
      $display("FAIL frac7 span/stretched: got %0d/%0d want 39/7", sum, str);
    end
  endtask

  task automatic test_div0();
    int n;
    int exp_p[4] = '{1, 2, 1, 2};
    setup(13'd0, 3'd4);
    wait_tick(0, '0, '0, n);
    for (int i = 0; i < 4; i++) begin
      wait_tick(0, '0, '0, n);
      n_cmp++;
      if (n !== exp_p[i]) begin
        n_bad++;
        $display("FAIL div0 period %0d: got %0d want %0d", i, n, exp_p[i]);
      end
    end
  endtask

  task automatic test_load_mid();
    int n;
    int exp_p[5] = '{10, 3, 3, 3, 7};
    int got_p[5];
    setup(13'd9, 3'd0);
    wait_tick(0, '0, '0, n);
    wait_tick(3, 13'd2, 3'd0, got_p[0]);  // load mid-period
    wait_tick(0, '0, '0, got_p[1]);
    wait_tick(2, 13'd6, 3'd0, got_p[2]);  // load coincident with tick
    wait_tick(0, '0, '0, got_p[3]);
    wait_tick(0, '0, '0, got_p[4]);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (got_p[i] !== exp_p[i]) begin
        n_bad++;
        $display("FAIL load period %0d: got %0d want %0d", i, got_p[i], exp_p[i]);
      end
    end
  endtask

  task automatic test_sync_clr();
    int n;
    setup(13'd3, 3'd4);
    wait_tick(0, '0, '0, n);
    @(posedge clk); #1;
    sync_clr = 1'b1;
    @(posedge clk); #1;
    sync_clr = 1'b0;
    n_cmp++;
    if ({baud_tick, xmit_pulse, rx_sample, ovs_phase} !== 7'b0) begin
      n_bad++;
      $display("FAIL sync_clr_edge: got %b want 0000000",
               {baud_tick, xmit_pulse, rx_sample, ovs_phase});
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({baud_tick, ovs_phase} !== 5'b1_0001) begin
      n_bad++;
      $display("FAIL sync_clr_restart: got %b want 10001", {baud_tick, ovs_phase});
    end
    // acc cleared: 0+4 no carry, then 4+4 carries.
    wait_tick(0, '0, '0, n);
    n_cmp++;
    if (n !== 4) begin
      n_bad++;
      $display("FAIL sync_clr_acc p0: got %0d want 4", n);
    end
    wait_tick(0, '0, '0, n);
    n_cmp++;
    if (n !== 5) begin
      n_bad++;
      $display("FAIL sync_clr_acc p1: got %0d want 5", n);
    end
    // Clear plus load landing on what would have been a tick edge.
    repeat (3) @(posedge clk); #1;
    sync_clr = 1'b1; baud_load = 1'b1; baud_val = 13'd1; baud_frac = 3'd0;
    @(posedge clk); #1;
    sync_clr = 1'b0; baud_load = 1'b0;
    n_cmp++;
    if ({baud_tick, ovs_phase} !== 5'b0) begin
      n_bad++;
      $display("FAIL sync_clr_override: got %b want 00000", {baud_tick, ovs_phase});
    end
    @(posedge clk); #1;
    n_cmp++;
    if (baud_tick !== 1'b1) begin
      n_bad++;
      $display("FAIL sync_clr_load_tick: got %b want 1", baud_tick);
    end
    wait_tick(0, '0, '0, n);
    n_cmp++;
    if (n !== 2) begin
      n_bad++;
      $display("FAIL sync_clr_load_period: got %0d want 2", n);
    end
  endtask

  task automatic test_enable_gap();
    int n;
    setup(13'd3, 3'd0);
    wait_tick(0, '0, '0, n);
    #1 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({baud_tick, xmit_pulse, rx_sample, ovs_phase} !== 7'b0) begin
      n_bad++;
      $display("FAIL async_reset: got %b want 0000000",
               {baud_tick, xmit_pulse, rx_sample, ovs_phase});
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    // Shadow was cleared too: ticks on two consecutive edges.
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++;
    if ({baud_tick, ovs_phase} !== 5'b1_0010) begin
      n_bad++;
      $display("FAIL reset_shadow_clear: got %b want 10010", {baud_tick, ovs_phase});
    end
    setup(13'd3, 3'd0);
    wait_tick(0, '0, '0, n);
    @(posedge clk); #1;
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({baud_tick, ovs_phase} !== 5'b0_0001) begin
        n_bad++;
        $display("FAIL enable_gap hold %0d: got %b want 00001", i, {baud_tick, ovs_phase});
      end
    end
    enable = 1'b1;
    wait_tick(0, '0, '0, n);
    n_cmp++;
    if (1 + 5 + n !== 9 || ovs_phase !== 4'd2) begin
      n_bad++;
      $display("FAIL enable_gap period: got %0d phase %0d want 9 phase 2", 1 + 5 + n, ovs_phase);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_frac_half();
    test_frac_max();
    test_div0();
    test_load_mid();
    test_sync_clr();
    test_enable_gap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
